// File: rtl/core_pkg.sv
// Shared RV32I core constants and encodings used by the writeback stage.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Writeback source select
  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

  // Load funct3 encodings
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/half/word addressed by the byte
// offset, sign- or zero-extends it, and flags misaligned half/word loads.
module load_align
  import core_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result,
  output logic            misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Extract lane, then extend according to load type
  always_comb begin
    case (offset)
      2'd0:    byte_v = data[7:0];
      2'd1:    byte_v = data[15:8];
      2'd2:    byte_v = data[23:16];
      default: byte_v = data[31:24];
    endcase
    half_v = offset[1] ? data[31:16] : data[15:0];

    result     = '0;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:   result = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  result = {24'h0, byte_v};
      F3_LH: begin
        result     = {{16{half_v[15]}}, half_v};
        misaligned = offset[0];
      end
      F3_LHU: begin
        result     = {16'h0, half_v};
        misaligned = offset[0];
      end
      F3_LW: begin
        result     = data;
        misaligned = |offset;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register: aligns load data, selects the writeback source
// and drives the register-file write port one cycle after capture.
// Optional build macro WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module writeback_stage #(
  parameter int unsigned XLEN       = core_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [1:0]            mem_wb_sel,
  input  logic [2:0]            mem_funct3,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [XLEN-1:0]       mem_pc_plus4,
  input  logic [XLEN-1:0]       mem_load_data,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_rd_data,
  output logic                  wb_reg_write,
  output logic                  wb_misaligned
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]           instret
`endif
);

  import core_pkg::*;

  logic [XLEN-1:0] load_result;
  logic            load_mis;
  logic            misaligned;
  logic [XLEN-1:0] next_data;
  logic            next_reg_write;

  load_align u_load_align (
    .data       (mem_load_data),
    .offset     (mem_alu_result[1:0]),
    .funct3     (mem_funct3),
    .result     (load_result),
    .misaligned (load_mis)
  );

  // Source mux and write-enable qualification for the incoming instruction
  always_comb begin
    misaligned = (mem_wb_sel == WB_SEL_LOAD) && load_mis;
    case (mem_wb_sel)
      WB_SEL_ALU:  next_data = mem_alu_result;
      WB_SEL_LOAD: next_data = load_result;
      WB_SEL_PC4:  next_data = mem_pc_plus4;
      default:     next_data = '0;
    endcase
    next_reg_write = mem_valid && mem_reg_write && (mem_rd != '0) &&
                     !misaligned && (mem_wb_sel != WB_SEL_RSVD);
  end

  // Stage registers: rst > flush > stall > capture
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_rd_data    <= '0;
      wb_reg_write  <= 1'b0;
      wb_misaligned <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= mem_valid;
      wb_rd         <= mem_rd;
      wb_rd_data    <= next_data;
      wb_reg_write  <= next_reg_write;
      wb_misaligned <= mem_valid && misaligned;
    end
  end

`ifdef WB_INSTRET_EN
  // Count instructions that retire cleanly into WB; wraps naturally at 2^64
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
    end else if (!flush && !stall && mem_valid && !misaligned) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic [31:0] mem_load_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rd_data;
  logic        wb_reg_write;
  logic        wb_misaligned;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_pc_plus4   (mem_pc_plus4),
    .mem_load_data  (mem_load_data),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_rd_data     (wb_rd_data),
    .wb_reg_write   (wb_reg_write),
    .wb_misaligned  (wb_misaligned)
`ifdef WB_INSTRET_EN
    ,
    .instret        (instret)
`endif
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] ld;
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] edata;
    logic        erw;
    logic        emis;
    logic        dc;    // rd/data are don't-care (flush)
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [63:0] exp_instret = '0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic valid, input logic rw, input logic [4:0] rd,
                              input logic [1:0] sel, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [31:0] ld, input logic flush,
                              input logic ev, input logic [4:0] erd,
                              input logic [31:0] edata, input logic erw,
                              input logic emis, input logic dc);
    vec_t v;
    v.stall = 1'b0; v.flush = flush; v.valid = valid; v.rw = rw; v.rd = rd;
    v.sel = sel; v.f3 = f3; v.alu = alu; v.pc4 = pc4; v.ld = ld;
    v.ev = ev; v.erd = erd; v.edata = edata; v.erw = erw; v.emis = emis; v.dc = dc;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check(input string tag, input logic ev, input logic [4:0] erd,
                       input logic [31:0] ed, input logic erw, input logic emis,
                       input logic dc);
    n_vec++;
    cmp({tag, ".valid"}, {63'h0, wb_valid}, {63'h0, ev});
    cmp({tag, ".reg_write"}, {63'h0, wb_reg_write}, {63'h0, erw});
    cmp({tag, ".misaligned"}, {63'h0, wb_misaligned}, {63'h0, emis});
    if (!dc) begin
      cmp({tag, ".rd"}, {59'h0, wb_rd}, {59'h0, erd});
      cmp({tag, ".rd_data"}, {32'h0, wb_rd_data}, {32'h0, ed});
    end
`ifdef WB_INSTRET_EN
    cmp({tag, ".instret"}, instret, exp_instret);
`endif
  endtask

  task automatic drive(input vec_t v);
    stall          = v.stall;
    flush          = v.flush;
    mem_valid      = v.valid;
    mem_reg_write  = v.rw;
    mem_rd         = v.rd;
    mem_wb_sel     = v.sel;
    mem_funct3     = v.f3;
    mem_alu_result = v.alu;
    mem_pc_plus4   = v.pc4;
    mem_load_data  = v.ld;
  endtask

  task automatic apply(input string tag, input vec_t v);
    drive(v);
    @(posedge clk);
    if (!rst && !v.flush && !v.stall && v.valid && !v.emis) exp_instret++;
    #1;
    check(tag, v.ev, v.erd, v.edata, v.erw, v.emis, v.dc);
  endtask

  localparam logic [31:0] LD = 32'h80FF_1234;

  initial begin
    vec_t v;
    vec_t idle;
    idle = mk(0, 0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0);

    // Reset: 2 cycles with busy inputs, then release with idle inputs
    rst = 1'b1;
    drive(mk(1, 1, 5, 2'b01, 3'b000, 32'h103, 32'h4, LD, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("reset1", 0, 0, 32'h0, 0, 0, 0);
    @(posedge clk); #1;
    check("reset2", 0, 0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    apply("post_reset", idle);

    // Single-cycle vectors
    vecs.push_back(mk(1, 1, 5,  2'b01, 3'b000, 32'h103, 0, LD, 0, 1, 5,  32'hFFFF_FF80, 1, 0, 0));
    vecs.push_back(mk(1, 1, 5,  2'b01, 3'b100, 32'h103, 0, LD, 0, 1, 5,  32'h0000_0080, 1, 0, 0));
    vecs.push_back(mk(1, 1, 5,  2'b01, 3'b001, 32'h101, 0, LD, 0, 1, 5,  32'h0000_1234, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0,  2'b00, 3'b000, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0));
    vecs.push_back(mk(1, 1, 7,  2'b01, 3'b010, 32'h100, 0, LD, 0, 1, 7,  32'h80FF_1234, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8,  2'b01, 3'b101, 32'h102, 0, LD, 0, 1, 8,  32'h0000_80FF, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8,  2'b01, 3'b001, 32'h102, 0, LD, 0, 1, 8,  32'hFFFF_80FF, 1, 0, 0));
    vecs.push_back(mk(1, 1, 10, 2'b01, 3'b000, 32'h100, 0, LD, 0, 1, 10, 32'h0000_0034, 1, 0, 0));
    vecs.push_back(mk(1, 1, 10, 2'b01, 3'b000, 32'h101, 0, LD, 0, 1, 10, 32'h0000_0012, 1, 0, 0));
    vecs.push_back(mk(1, 1, 10, 2'b01, 3'b000, 32'h102, 0, LD, 0, 1, 10, 32'hFFFF_FFFF, 1, 0, 0));
    vecs.push_back(mk(1, 1, 11, 2'b01, 3'b010, 32'h102, 0, LD, 0, 1, 11, 32'h80FF_1234, 0, 1, 0));
    vecs.push_back(mk(1, 1, 13, 2'b01, 3'b101, 32'h103, 0, LD, 0, 1, 13, 32'h0000_80FF, 0, 1, 0));
    vecs.push_back(mk(1, 1, 3,  2'b01, 3'b011, 32'h100, 0, LD, 0, 1, 3,  32'h0000_0000, 1, 0, 0));
    vecs.push_back(mk(1, 1, 4,  2'b11, 3'b000, 32'h55, 32'h44, LD, 0, 1, 4, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 6,  2'b01, 3'b001, 32'h101, 0, LD, 0, 0, 6,  32'h0000_1234, 0, 0, 0));
    vecs.push_back(mk(1, 0, 12, 2'b00, 3'b000, 32'h77, 0, 0, 0, 1, 12, 32'h77, 0, 0, 0));
    vecs.push_back(mk(1, 1, 9,  2'b00, 3'b001, 32'h1, 0, LD, 0, 1, 9,  32'h1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 31, 2'b10, 3'b000, 32'h3, 32'h2004, LD, 0, 1, 31, 32'h2004, 1, 0, 0));
    vecs.push_back(mk(1, 1, 5,  2'b01, 3'b001, 32'h101, 0, LD, 1, 0, 0,  32'h0, 0, 0, 1));
    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // JAL-style capture, then 3 stall cycles with different inputs presented
    apply("pc4_cap", mk(1, 1, 1, 2'b10, 3'b000, 32'h0, 32'h0000_1008, 0, 0, 1, 1, 32'h1008, 1, 0, 0));
    v = mk(1, 1, 2, 2'b00, 3'b000, 32'hAAAA, 0, 0, 0, 1, 1, 32'h1008, 1, 0, 0);
    v.stall = 1'b1;
    for (int i = 0; i < 3; i++) apply($sformatf("stall_hold%0d", i), v);
    v = mk(1, 1, 2, 2'b00, 3'b000, 32'hAAAA, 0, 0, 1, 0, 0, 32'h0, 0, 0, 1);
    v.stall = 1'b1;
    apply("flush_stall", v);

    // Misaligned pulse holds under stall, then ends
    apply("mis_cap", mk(1, 1, 5, 2'b01, 3'b001, 32'h101, 0, LD, 0, 1, 5, 32'h1234, 0, 1, 0));
    v = mk(1, 1, 6, 2'b00, 3'b000, 32'h9, 0, 0, 0, 1, 5, 32'h1234, 0, 1, 0);
    v.stall = 1'b1;
    apply("mis_stall", v);
    apply("mis_end", idle);

    // Reset asserted during stall wins and returns to power-up state
    apply("pre_rst", mk(1, 1, 3, 2'b00, 3'b000, 32'h42, 0, 0, 0, 1, 3, 32'h42, 1, 0, 0));
    rst = 1'b1;
    v = mk(1, 1, 3, 2'b00, 3'b000, 32'h42, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    v.stall = 1'b1;
    exp_instret = '0;
    apply("rst_in_stall", v);
    rst = 1'b0;

    // Back-to-back: 4 valid instructions, then a bubble
    for (int i = 1; i <= 4; i++) begin
      apply($sformatf("b2b%0d", i),
            mk(1, 1, 5'(i), 2'b00, 3'b000, 32'(i * 17), 0, 0, 0,
               1, 5'(i), 32'(i * 17), 1, 0, 0));
    end
    apply("b2b_bubble", idle);
`ifdef WB_INSTRET_EN
    n_vec++;
    cmp("instret_4", instret, 64'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline stage of the RV32I core; sits directly upstream of the register file.
- Registers memory-stage results and aligns/extends load data by funct3 and byte offset.
- Selects the writeback source and drives the register-file write port (rd, rd_data, reg_write).
- Handles stall, flush and misaligned-load suppression.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hold all stage registers.
- flush  in  1  kill the incoming instruction.
- mem_valid  in  1  memory stage holds a valid instruction.
- mem_reg_write  in  1  instruction writes rd.
- mem_rd  in  5  destination register.
- mem_wb_sel  in  2  writeback source: 00 ALU, 01 LOAD, 10 PC+4, 11 reserved.
- mem_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_alu_result  in  32  ALU result or load address; [1:0] is the byte offset.
- mem_pc_plus4  in  32  link value.
- mem_load_data  in  32  raw aligned-word read data.
- wb_valid  out  1  WB stage holds a valid instruction.
- wb_rd  out  5  to register-file rd.
- wb_rd_data  out  32  to register-file rd_data.
- wb_reg_write  out  1  to register-file reg_write.
- wb_misaligned  out  1  load-misaligned exception pulse.

Behaviour:
- Latency: 1 cycle. Capture is at posedge; outputs come directly from flops with no combinational path from input to output.
- Load alignment runs before capture:
  - LB/LBU take byte [offset*8 +: 8].
  - LH/LHU take half [offset[1]*16 +: 16].
  - LW takes the whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 yields 0.
- Misaligned: LH/LHU with offset[0]=1, or LW with offset!=0, when wb_sel=LOAD.
- Source select:
  - 00: alu_result.
  - 01: aligned load.
  - 10: pc_plus4.
  - 11: 0, with reg_write forced low.
- Priority each posedge: rst > flush > stall > normal capture.
- rst: wb_valid=0, wb_reg_write=0, wb_misaligned=0, wb_rd=0, wb_rd_data=0.
- flush, with or without stall: wb_valid=0, wb_reg_write=0, wb_misaligned=0; wb_rd and wb_rd_data are don't-care, and zeroed is preferred.
- stall without flush: all outputs hold their current values. wb_reg_write holds too; rewriting the same value is harmless, and the regfile sees the write again.
- Normal capture:
  - wb_valid = mem_valid.
  - wb_misaligned = mem_valid & misaligned.
  - wb_reg_write = mem_valid & mem_reg_write & (mem_rd!=0) & ~misaligned & (wb_sel!=11).
- x0: never asserts reg_write for rd=0; wb_rd_data still shows the computed value.
- wb_misaligned is a single-cycle pulse per instruction. While stalled it holds; the trap unit samples it only on non-stall cycles.
- Reset mid-stall or mid-flush: rst wins, and state after rst is the same as at power-up.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - Adds output instret [63:0], reset to 0.
  - Increments by 1 on each posedge where a valid, non-misaligned instruction is captured, i.e. not stalled, not flushed, mem_valid=1, misaligned=0.
  - Wraps modulo 2^64.
- Undefined: no port and no counter logic.

Decomposition:
- Package core_pkg holds:
  - WB_SEL_ALU/LOAD/PC4/RSVD.
  - F3_LB/LH/LW/LBU/LHU.
  - XLEN and REG_ADDR_W constants.
- Sub-module load_align (combinational) takes data, offset and funct3, and produces result and misaligned.

Test Plan:
- rst high 2 cycles, then low -> all outputs 0; with WB_INSTRET_EN, instret=0.
- LB, addr …03, load_data 0x80FF_1234, rd=5, reg_write=1 -> next cycle wb_rd_data=0xFFFF_FF80, wb_rd=5, wb_reg_write=1. Same stimulus with LBU -> 0x0000_0080.
- LH, addr …01 -> wb_misaligned=1, wb_reg_write=0, wb_valid=1. With WB_INSTRET_EN, instret unchanged.
- wb_sel=10, pc_plus4=0x0000_1008, rd=1, with stall held 3 cycles after capture -> outputs constant for 3 cycles. Then flush+stall together -> wb_valid=0, wb_reg_write=0.
- ALU result 0xDEAD_BEEF, rd=0, reg_write=1 -> wb_reg_write=0, wb_valid=1, wb_rd_data=0xDEAD_BEEF.
- Back-to-back: 4 valid instructions with no stall, then mem_valid=0 -> wb_valid=1 for 4 cycles then 0; with WB_INSTRET_EN, instret=4.
